// File: rtl/dmem_lsu_master.sv
// Load/store initiator for the ic0 word bus: one RV32 request at a time, sub-word stores done
// as read-modify-write, reads bounded by a timeout that returns an error response.
module dmem_lsu_master #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TO_W    = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        ic0_c_axi_mst_rd_valid,
   output logic [31:0] ic0_axi_mst_rd_addr,
   input  logic        ic0_c_axi_slv_rd_ready_2,
   input  logic [31:0] ic0_axi_slv_rd_data_2,
   output logic        ic0_c_axi_mst_wr_valid,
   output logic [31:0] ic0_axi_mst_wr_addr,
   output logic [31:0] ic0_axi_mst_wr_data
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

   state_e            state_q;
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [1:0]        addr_q;
   logic [15:0]       wdata_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic              req_ready_q, rsp_valid_q, rsp_err_q, rd_valid_q, wr_valid_q;
   logic [31:0]       rsp_rdata_q, rd_addr_q, wr_addr_q, wr_data_q;

   logic              misaligned;
   logic [4:0]        lane_sh;
   logic [31:0]       shifted, load_data, lane_mask, merge_data;

   always_comb begin
      misaligned = (req_size == 2'd3) ||
                   ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
   end

   // Load extraction and store merge both work on the lane selected by the latched address.
   always_comb begin
      lane_sh   = {addr_q, 3'b000};
      shifted   = ic0_axi_slv_rd_data_2 >> lane_sh;
      load_data = shifted;
      lane_mask = 32'h0000_00FF;
      if (size_q == 2'd0) begin
         load_data = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end else if (size_q == 2'd1) begin
         load_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         lane_mask = 32'h0000_FFFF;
      end
      merge_data = (ic0_axi_slv_rd_data_2 & ~(lane_mask << lane_sh)) |
                   (({16'h0, wdata_q} & lane_mask) << lane_sh);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         we_q        <= 1'b0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
         addr_q      <= 2'd0;
         wdata_q     <= 16'h0;
         to_cnt_q    <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rd_valid_q  <= 1'b0;
         rd_addr_q   <= 32'h0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= 32'h0;
         wr_data_q   <= 32'h0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  we_q        <= req_we;
                  size_q      <= req_size;
                  uns_q       <= req_unsigned;
                  addr_q      <= req_addr[1:0];
                  wdata_q     <= req_wdata[15:0];
                  req_ready_q <= 1'b0;
                  if (misaligned) begin
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= 32'h0;
                  end else if (!req_we || (req_size != 2'd2)) begin
                     state_q    <= StRd;
                     rd_valid_q <= 1'b1;
                     rd_addr_q  <= {2'b00, req_addr[31:2]};
                     to_cnt_q   <= '0;
                  end else begin
                     state_q    <= StWr;
                     wr_valid_q <= 1'b1;
                     wr_addr_q  <= {2'b00, req_addr[31:2]};
                     wr_data_q  <= req_wdata;
                  end
               end
            end
            StRd: begin
               if (ic0_c_axi_slv_rd_ready_2) begin
                  rd_valid_q <= 1'b0;
                  if (we_q) begin
                     state_q    <= StWr;
                     wr_valid_q <= 1'b1;
                     wr_addr_q  <= rd_addr_q;
                     wr_data_q  <= merge_data;
                  end else begin
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_rdata_q <= load_data;
                  end
               end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                  // Give up; a pending read-modify-write is dropped without writing.
                  rd_valid_q  <= 1'b0;
                  state_q     <= StResp;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 32'h0;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            StWr: begin
               wr_valid_q  <= 1'b0;
               state_q     <= StResp;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= 32'h0;
            end
            StResp: begin
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= 32'h0;
               req_ready_q <= 1'b1;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready              = req_ready_q;
   assign rsp_valid              = rsp_valid_q;
   assign rsp_rdata              = rsp_rdata_q;
   assign rsp_err                = rsp_err_q;
   assign ic0_c_axi_mst_rd_valid = rd_valid_q;
   assign ic0_axi_mst_rd_addr    = rd_addr_q;
   assign ic0_c_axi_mst_wr_valid = wr_valid_q;
   assign ic0_axi_mst_wr_addr    = wr_addr_q;
   assign ic0_axi_mst_wr_data    = wr_data_q;

endmodule

// File: tb/tb_dmem_lsu_master.sv
// Directed bench for dmem_lsu_master: a 256-word memory responder, a response scoreboard and
// per-request checks of latency, bus activity and addresses.
module tb_dmem_lsu_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        rd_valid, rd_ready, wr_valid;
   logic [31:0] rd_addr, rd_data, wr_addr, wr_data;

   logic [31:0] mem [256];
   logic [32:0] sb_q [$];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   dmem_lsu_master #(.TIMEOUT(16), .TO_W(5)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .req_valid                (req_valid),
      .req_ready                (req_ready),
      .req_we                   (req_we),
      .req_size                 (req_size),
      .req_unsigned             (req_unsigned),
      .req_addr                 (req_addr),
      .req_wdata                (req_wdata),
      .rsp_valid                (rsp_valid),
      .rsp_rdata                (rsp_rdata),
      .rsp_err                  (rsp_err),
      .ic0_c_axi_mst_rd_valid   (rd_valid),
      .ic0_axi_mst_rd_addr      (rd_addr),
      .ic0_c_axi_slv_rd_ready_2 (rd_ready),
      .ic0_axi_slv_rd_data_2    (rd_data),
      .ic0_c_axi_mst_wr_valid   (wr_valid),
      .ic0_axi_mst_wr_addr      (wr_addr),
      .ic0_axi_mst_wr_data      (wr_data)
   );

   // Responder: answers in the same cycle for word addresses below 256, never otherwise.
   always_comb begin
      rd_ready = rd_valid && (rd_addr < 32'd256);
      rd_data  = mem[rd_addr[7:0]];
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[16] <= 32'h8899_AABB;
      end else if (wr_valid && (wr_addr < 32'd256)) begin
         mem[wr_addr[7:0]] <= wr_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input int exp_rd, input int exp_wr, input logic [31:0] exp_baddr,
                         input logic [31:0] exp_wdata);
      int          lat, rd_n, wr_n, both;
      logic        got;
      logic [31:0] last_rd, last_wa, last_wd;
      logic [32:0] exp;
      @(negedge clk);
      chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
      chk({tag, " idle rsp"}, {31'h0, rsp_valid}, 32'h0);
      sb_q.push_back({exp_err, exp_rdata});
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      lat = 1; rd_n = 0; wr_n = 0; both = 0; got = 1'b0;
      last_rd = 32'h0; last_wa = 32'h0; last_wd = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         lat++;
         if (rd_valid) begin rd_n++; last_rd = rd_addr; end
         if (wr_valid) begin wr_n++; last_wa = wr_addr; last_wd = wr_data; end
         if (rd_valid && wr_valid) both++;
         if (rsp_valid) got = 1'b1;
         else @(negedge clk);
      end
      exp = sb_q.pop_front();
      if (got) begin
         chk({tag, " rdata"}, rsp_rdata, exp[31:0]);
         chk({tag, " err"}, {31'h0, rsp_err}, {31'h0, exp[32]});
         chk({tag, " latency"}, lat, exp_lat);
      end else begin
         n_cmp++;
         n_err++;
         $error("FAIL %s timeout: observed no rsp_valid expected rsp_valid", tag);
      end
      chk({tag, " rd cycles"}, rd_n, exp_rd);
      chk({tag, " wr pulses"}, wr_n, exp_wr);
      chk({tag, " rd&wr"}, both, 0);
      if (rd_n != 0) chk({tag, " rd_addr"}, last_rd, exp_baddr);
      if (wr_n != 0) begin
         chk({tag, " wr_addr"}, last_wa, exp_baddr);
         chk({tag, " wr_data"}, last_wd, exp_wdata);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr_n, rsp_n;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst rsp", {29'h0, rsp_valid, rsp_err, rd_valid}, 32'h0);
      chk("rst wr_valid", {31'h0, wr_valid}, 32'h0);
      chk("rst rdata", rsp_rdata, 32'h0);
      chk("rst buses", rd_addr | wr_addr | wr_data, 32'h0);
      reset = 1'b0;

      //      tag   we    sz    uns   addr          wdata        rdata         err  lat rd wr baddr         wdata
      do_req("LB",  1'b0, 2'd0, 1'b0, 32'h41,       32'h0,       32'hFFFF_FFAA, 1'b0, 3, 1, 0, 32'h10,     32'h0);
      do_req("LBU", 1'b0, 2'd0, 1'b1, 32'h41,       32'h0,       32'h0000_00AA, 1'b0, 3, 1, 0, 32'h10,     32'h0);
      do_req("LH",  1'b0, 2'd1, 1'b0, 32'h42,       32'h0,       32'hFFFF_8899, 1'b0, 3, 1, 0, 32'h10,     32'h0);
      do_req("LHU", 1'b0, 2'd1, 1'b1, 32'h42,       32'h0,       32'h0000_8899, 1'b0, 3, 1, 0, 32'h10,     32'h0);
      do_req("LW",  1'b0, 2'd2, 1'b0, 32'h40,       32'h0,       32'h8899_AABB, 1'b0, 3, 1, 0, 32'h10,     32'h0);
      do_req("SB",  1'b1, 2'd0, 1'b0, 32'h43,       32'h55,      32'h0,         1'b0, 4, 1, 1, 32'h10,     32'h5599_AABB);
      do_req("SH",  1'b1, 2'd1, 1'b0, 32'h40,       32'hBEEF_CAFE, 32'h0,       1'b0, 4, 1, 1, 32'h10,     32'h5599_CAFE);
      do_req("LW2", 1'b0, 2'd2, 1'b1, 32'h40,       32'h0,       32'h5599_CAFE, 1'b0, 3, 1, 0, 32'h10,     32'h0);
      do_req("SWF", 1'b1, 2'd2, 1'b0, 32'h4_0000,   32'hDEAD_BEEF, 32'h0,       1'b0, 3, 0, 1, 32'h1_0000, 32'hDEAD_BEEF);
      do_req("LWT", 1'b0, 2'd2, 1'b0, 32'h4_0000,   32'h0,       32'h0,         1'b1, 18, 16, 0, 32'h1_0000, 32'h0);
      do_req("MLH", 1'b0, 2'd1, 1'b0, 32'h41,       32'h0,       32'h0,         1'b1, 2, 0, 0, 32'h0,      32'h0);
      do_req("MLW", 1'b0, 2'd2, 1'b0, 32'h42,       32'h0,       32'h0,         1'b1, 2, 0, 0, 32'h0,      32'h0);
      do_req("SZ3", 1'b1, 2'd3, 1'b0, 32'h40,       32'h1,       32'h0,         1'b1, 2, 0, 0, 32'h0,      32'h0);
      do_req("SW0", 1'b1, 2'd2, 1'b0, 32'h0,        32'h1234_5678, 32'h0,       1'b0, 3, 0, 1, 32'h0,      32'h1234_5678);
      do_req("LW0", 1'b0, 2'd2, 1'b0, 32'h0,        32'h0,       32'h1234_5678, 1'b0, 3, 1, 0, 32'h0,      32'h0);

      // Sub-word store to an address the responder never answers, then reset while it waits.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h4_0001;
      req_wdata = 32'hAB;
      wr_n = 0; rsp_n = 0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("RST in RD", {31'h0, rd_valid}, 32'h1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("RST req_ready", {31'h0, req_ready}, 32'h1);
      chk("RST rd_valid", {31'h0, rd_valid}, 32'h0);
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (wr_valid) wr_n++;
         if (rsp_valid) rsp_n++;
      end
      chk("RST wr pulses", wr_n, 0);
      chk("RST rsp pulses", rsp_n, 0);
      chk("RST idle ready", {31'h0, req_ready}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
